// File: rtl/conv_window_ctrl.sv
// Frame sequencer for the K x K convolution window: raster position, line-buffer strobes, window tags (CONV_STRIDE2_EN selects stride 2).
// Window outputs register one cycle after the accepting edge; i_stall or i_abort drop o_ready in the same cycle.
module conv_window_ctrl #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int K     = 5,
  parameter int CW    = $clog2(IMG_W*IMG_H+1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic                      i_valid,
  input  logic                      i_stall,
  output logic                      o_ready,
  output logic                      o_lb_wr_en,
  output logic                      o_win_valid,
  output logic [$clog2(IMG_H)-1:0]  o_win_row,
  output logic [$clog2(IMG_W)-1:0]  o_win_col,
  output logic [CW-1:0]             o_win_cnt,
  output logic                      o_busy,
  output logic                      o_frame_done
);
  localparam int RW = $clog2(IMG_H);
  localparam int XW = $clog2(IMG_W);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q;
  logic [XW-1:0] col_q;
  logic          accept;
  logic          last_col, last_row, fill_last;
  logic          clear;
  logic          win_base, win_hit;
  logic [RW-1:0] row_off, row_idx;
  logic [XW-1:0] col_off, col_idx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_start) state_d = FILL;
      FILL: begin
        if (i_abort)                  state_d = IDLE;
        else if (accept && fill_last) state_d = RUN;
      end
      RUN: begin
        if (i_abort)                            state_d = IDLE;
        else if (accept && last_row && last_col) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready      = ((state_q == FILL) || (state_q == RUN)) && !i_stall && !i_abort;
    o_busy       = (state_q != IDLE);
    o_frame_done = (state_q == DONE) && !i_abort;
  end

  assign accept     = i_valid && o_ready;
  assign o_lb_wr_en = accept;
  assign clear      = (state_q != IDLE) && i_abort;

  assign last_col  = (col_q == XW'(IMG_W-1));
  assign last_row  = (row_q == RW'(IMG_H-1));
  assign fill_last = (row_q == RW'(K-2)) && last_col;

  // Offsets are only consumed when win_base holds, so they never wrap.
  assign row_off  = row_q - RW'(K-1);
  assign col_off  = col_q - XW'(K-1);
  assign win_base = (row_q >= RW'(K-1)) && (col_q >= XW'(K-1));

`ifdef CONV_STRIDE2_EN
  assign win_hit = win_base && !row_off[0] && !col_off[0];
  assign row_idx = row_off >> 1;
  assign col_idx = col_off >> 1;
`else
  assign win_hit = win_base;
  assign row_idx = row_off;
  assign col_idx = col_off;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if ((state_q == IDLE) || clear) begin
      row_q <= '0;
      col_q <= '0;
    end else if (accept) begin
      col_q <= last_col ? '0 : col_q + 1'b1;
      if (last_col) row_q <= last_row ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_win_valid <= 1'b0;
      o_win_row   <= '0;
      o_win_col   <= '0;
    end else begin
      o_win_valid <= accept && win_hit;
      if (accept && win_hit) begin
        o_win_row <= row_idx;
        o_win_col <= col_idx;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_win_cnt <= '0;
    end else if (((state_q == IDLE) && i_start) || clear) begin
      o_win_cnt <= '0;
    end else if (o_win_valid && (o_win_cnt != '1)) begin
      o_win_cnt <= o_win_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: random pixel gaps checked against a raster-arithmetic window model.
module tb_conv_window_ctrl;
  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int K     = 5;
  localparam int CW    = $clog2(IMG_W*IMG_H+1);
  localparam int RW    = $clog2(IMG_H);
  localparam int XW    = $clog2(IMG_W);
`ifdef CONV_STRIDE2_EN
  localparam int STRIDE = 2;
`else
  localparam int STRIDE = 1;
`endif
  localparam int NPIX     = IMG_W*IMG_H;
  localparam int EXP_WINS = ((IMG_W-K+STRIDE)/STRIDE) * ((IMG_H-K+STRIDE)/STRIDE);
  localparam int LAST_IDX = (IMG_W-K)/STRIDE;
  localparam int BUDGET   = 4*NPIX + 100;

  logic i_clk = 1'b0;
  logic i_rst, i_start, i_abort, i_valid, i_stall;
  logic o_ready, o_lb_wr_en, o_win_valid, o_busy, o_frame_done;
  logic [RW-1:0] o_win_row;
  logic [XW-1:0] o_win_col;
  logic [CW-1:0] o_win_cnt;

  conv_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_valid(i_valid), .i_stall(i_stall), .o_ready(o_ready), .o_lb_wr_en(o_lb_wr_en),
    .o_win_valid(o_win_valid), .o_win_row(o_win_row), .o_win_col(o_win_col),
    .o_win_cnt(o_win_cnt), .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Model: 0 idle, 1 loading/running, 2 done
  int   m_st, m_pix, n_acc, e_cnt, e_row, e_col;
  logic e_wv;

  logic          ob_ready, ob_wr, ob_wv, ob_busy, ob_done;
  logic [RW-1:0] ob_row;
  logic [XW-1:0] ob_col;
  logic [CW-1:0] ob_cnt;
  int            ob_nacc;
  logic          ex_ready, ex_done, ex_busy, acc, xv;
  int            xr, xc, xcnt;

  task automatic model_reset();
    m_st = 0; m_pix = 0; n_acc = 0; e_cnt = 0; e_row = 0; e_col = 0; e_wv = 1'b0;
  endtask

  // Drives one cycle from a negedge, samples the DUT mid-cycle, advances the model.
  task automatic cyc(input logic v, input logic s, input logic a, input logic st);
    int r, c;
    i_valid = v; i_stall = s; i_abort = a; i_start = st;
    #1;
    ob_ready = o_ready; ob_wr = o_lb_wr_en; ob_wv = o_win_valid; ob_row = o_win_row;
    ob_col = o_win_col; ob_cnt = o_win_cnt; ob_busy = o_busy; ob_done = o_frame_done;
    ob_nacc  = n_acc;
    ex_ready = (m_st == 1) && !s && !a;
    ex_done  = (m_st == 2) && !a;
    ex_busy  = (m_st != 0);
    xv = e_wv; xr = e_row; xc = e_col; xcnt = e_cnt;
    acc = v && ex_ready;
    if (e_wv && e_cnt < (2**CW)-1) e_cnt++;
    e_wv = 1'b0;
    case (m_st)
      0: if (st) begin m_st = 1; m_pix = 0; e_cnt = 0; end
      1: begin
        if (a) begin
          m_st = 0; m_pix = 0; e_cnt = 0;
        end else if (acc) begin
          r = m_pix / IMG_W;
          c = m_pix % IMG_W;
          if (r >= K-1 && c >= K-1 && ((r-(K-1)) % STRIDE == 0) && ((c-(K-1)) % STRIDE == 0)) begin
            e_wv = 1'b1; e_row = (r-(K-1))/STRIDE; e_col = (c-(K-1))/STRIDE;
          end
          m_pix++; n_acc++;
          if (m_pix == NPIX) m_st = 2;
        end
      end
      default: begin m_st = 0; if (a) e_cnt = 0; end
    endcase
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_stall = 1'b0;
    #12;
    total++;
    if (o_ready !== 1'b0 || o_lb_wr_en !== 1'b0 || o_busy !== 1'b0 || o_frame_done !== 1'b0) begin
      bad++; $display("FAIL reset_comb: ready=%b wr=%b busy=%b done=%b want all 0", o_ready, o_lb_wr_en, o_busy, o_frame_done);
    end
    total++;
    if (o_win_valid !== 1'b0 || o_win_row !== '0 || o_win_col !== '0 || o_win_cnt !== '0) begin
      bad++; $display("FAIL reset_regs: v=%b row=%0d col=%0d cnt=%0d want 0", o_win_valid, o_win_row, o_win_col, o_win_cnt);
    end
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    i_valid = 1'b0;
  endtask

  task automatic test_full_frame();
    int wins = 0, dones = 0, first = -1, guard = 0, fr = -1, fc = -1;
    logic [RW-1:0] lr = '0;
    logic [XW-1:0] lc = '0;
    do begin
      cyc(logic'($urandom_range(0, 3) != 0), 1'b0, 1'b0, (guard == 0) ? 1'b1 : logic'($urandom_range(0, 7) == 0));
      guard++;
      total++; if (ob_ready !== ex_ready || ob_wr !== acc) begin bad++; $display("FAIL ff_ready: got %b/%b want %b/%b", ob_ready, ob_wr, ex_ready, acc); end
      total++; if (ob_wv !== xv || (xv && (ob_row !== RW'(xr) || ob_col !== XW'(xc))) || ob_cnt !== CW'(xcnt)) begin
        bad++; $display("FAIL ff_window: got v=%b (%0d,%0d) cnt=%0d want v=%b (%0d,%0d) cnt=%0d", ob_wv, ob_row, ob_col, ob_cnt, xv, xr, xc, xcnt); end
      total++; if (ob_done !== ex_done || ob_busy !== ex_busy) begin bad++; $display("FAIL ff_status: done=%b busy=%b want %b/%b", ob_done, ob_busy, ex_done, ex_busy); end
      if (ob_wv === 1'b1) begin
        wins++; lr = ob_row; lc = ob_col;
        if (first < 0) begin first = ob_nacc; fr = int'(ob_row); fc = int'(ob_col); end
      end
      if (ob_done === 1'b1) dones++;
    end while (m_st != 0 && guard < BUDGET);
    total++; if (guard >= BUDGET) begin bad++; $display("FAIL ff_timeout: %0d cycles, frame not finished", guard); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (ob_cnt !== CW'(EXP_WINS)) begin bad++; $display("FAIL ff_cnt: got %0d want %0d", ob_cnt, EXP_WINS); end
    total++; if (wins != EXP_WINS) begin bad++; $display("FAIL ff_wins: got %0d want %0d", wins, EXP_WINS); end
    total++; if (dones != 1) begin bad++; $display("FAIL ff_done_pulses: got %0d want 1", dones); end
    total++; if (first != (K-1)*IMG_W + K || fr != 0 || fc != 0) begin
      bad++; $display("FAIL ff_first: accept#%0d (%0d,%0d) want #%0d (0,0)", first, fr, fc, (K-1)*IMG_W + K); end
    total++; if (lr !== RW'(LAST_IDX) || lc !== XW'(LAST_IDX)) begin bad++; $display("FAIL ff_last: (%0d,%0d) want (%0d,%0d)", lr, lc, LAST_IDX, LAST_IDX); end
  endtask

  task automatic test_stall();
    int wins = 0, guard = 0, left = 10, stall_seen = 0;
    logic s;
    n_acc = 0;
    do begin
      s = (n_acc == 10*IMG_W + 15) && (left > 0);
      if (s) left--;
      cyc(1'b1, s, 1'b0, guard == 0);
      guard++;
      if (s && ob_ready === 1'b0 && ob_wr === 1'b0) stall_seen++;
      total++; if (ob_ready !== ex_ready || ob_wr !== acc) begin bad++; $display("FAIL st_ready: got %b/%b want %b/%b", ob_ready, ob_wr, ex_ready, acc); end
      total++; if (ob_wv !== xv || (xv && (ob_row !== RW'(xr) || ob_col !== XW'(xc))) || ob_cnt !== CW'(xcnt)) begin
        bad++; $display("FAIL st_window: got v=%b (%0d,%0d) cnt=%0d want v=%b (%0d,%0d) cnt=%0d", ob_wv, ob_row, ob_col, ob_cnt, xv, xr, xc, xcnt); end
      if (ob_wv === 1'b1) wins++;
    end while (m_st != 0 && guard < BUDGET);
    total++; if (guard >= BUDGET) begin bad++; $display("FAIL st_timeout: %0d cycles", guard); end
    total++; if (stall_seen != 10) begin bad++; $display("FAIL st_stalled_cycles: got %0d want 10", stall_seen); end
    total++; if (wins != EXP_WINS) begin bad++; $display("FAIL st_wins: got %0d want %0d", wins, EXP_WINS); end
  endtask

  task automatic test_abort();
    int guard = 0, dones = 0;
    n_acc = 0;
    do begin
      cyc(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 9) == 0), 1'b0, guard == 0);
      guard++;
      total++; if (ob_ready !== ex_ready || ob_wr !== acc) begin bad++; $display("FAIL ab_ready: got %b/%b want %b/%b", ob_ready, ob_wr, ex_ready, acc); end
      total++; if (ob_wv !== xv || (xv && (ob_row !== RW'(xr) || ob_col !== XW'(xc))) || ob_cnt !== CW'(xcnt)) begin
        bad++; $display("FAIL ab_window: got v=%b (%0d,%0d) cnt=%0d want v=%b (%0d,%0d) cnt=%0d", ob_wv, ob_row, ob_col, ob_cnt, xv, xr, xc, xcnt); end
    end while (n_acc < 500 && guard < BUDGET);
    total++; if (guard >= BUDGET) begin bad++; $display("FAIL ab_timeout: %0d cycles", guard); end
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, i == 0, 1'b0);
      total++; if (ob_ready !== ex_ready || ob_wr !== acc) begin bad++; $display("FAIL ab_post_ready: cyc %0d got %b/%b want %b/%b", i, ob_ready, ob_wr, ex_ready, acc); end
      total++; if (ob_done !== ex_done || ob_busy !== ex_busy || ob_cnt !== CW'(xcnt)) begin
        bad++; $display("FAIL ab_post_status: cyc %0d done=%b busy=%b cnt=%0d want %b/%b/%0d", i, ob_done, ob_busy, ob_cnt, ex_done, ex_busy, xcnt); end
      if (ob_done === 1'b1) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL ab_done: got %0d pulses want 0", dones); end
    n_acc = 0;
    test_full_frame();
  endtask

  task automatic test_back_to_back();
    int guard = 0, wins = 0, nd = 0, t0 = 0, t1 = 0;
    while (nd < 2 && guard < 3*NPIX) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      guard++;
      total++; if (ob_ready !== ex_ready || ob_done !== ex_done) begin bad++; $display("FAIL bb_ctrl: ready=%b done=%b want %b/%b", ob_ready, ob_done, ex_ready, ex_done); end
      if (ob_wv === 1'b1) wins++;
      if (ob_done === 1'b1) begin
        if (nd == 0) t0 = guard; else t1 = guard;
        nd++;
      end
    end
    total++; if (nd != 2 || t1 - t0 != NPIX + 2) begin bad++; $display("FAIL bb_period: frames=%0d period=%0d want 2/%0d", nd, t1 - t0, NPIX + 2); end
    total++; if (wins != 2*EXP_WINS) begin bad++; $display("FAIL bb_wins: got %0d want %0d", wins, 2*EXP_WINS); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    int guard = 0;
    n_acc = 0;
    do begin
      cyc(1'b1, 1'b0, 1'b0, guard == 0);
      guard++;
    end while (n_acc < 200 && guard < BUDGET);
    i_valid = 1'b1;
    #2 i_rst = 1'b1;
    #1;
    total++;
    if (o_ready !== 1'b0 || o_lb_wr_en !== 1'b0 || o_busy !== 1'b0 || o_frame_done !== 1'b0 ||
        o_win_valid !== 1'b0 || o_win_row !== '0 || o_win_col !== '0 || o_win_cnt !== '0) begin
      bad++; $display("FAIL ar_outputs: ready=%b wr=%b busy=%b done=%b v=%b row=%0d col=%0d cnt=%0d want all 0",
                      o_ready, o_lb_wr_en, o_busy, o_frame_done, o_win_valid, o_win_row, o_win_col, o_win_cnt);
    end
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      total++; if (ob_ready !== 1'b0 || ob_wr !== 1'b0 || ob_busy !== 1'b0 || ob_wv !== 1'b0 || ob_done !== 1'b0) begin
        bad++; $display("FAIL ar_idle: cyc %0d ready=%b wr=%b busy=%b v=%b done=%b want 0", i, ob_ready, ob_wr, ob_busy, ob_wv, ob_done); end
    end
    n_acc = 0;
    test_full_frame();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

Sequencing controller for the streaming 2-D convolution datapath. It accepts a raster-order pixel stream for one frame per start command and applies back-pressure from downstream. It tracks row and column position and drives line-buffer write enables. It flags each cycle on which the K×K window held by the line buffers is complete, so the MAC array's output is valid, and it tags that output with its coordinates. It replaces free-running valid gating with an explicit per-frame state machine that supports start, abort and done.

## Interface
- IMG_W, 32, pixels per row (≥ K)
- IMG_H, 32, rows per frame (≥ K)
- K, 5, kernel size (≥ 2)
- CW, $clog2(IMG_W*IMG_H+1), width of o_win_cnt

- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  start a frame; sampled only in IDLE
- i_abort  in  1  synchronous abort; returns the block to IDLE
- i_valid  in  1  input pixel present
- i_stall  in  1  downstream cannot take a window this cycle
- o_ready  out  1  pixel accepted when i_valid && o_ready
- o_lb_wr_en  out  1  line-buffer write strobe (combinational, = accept)
- o_win_valid  out  1  registered; window output valid
- o_win_row  out  $clog2(IMG_H)  output row of the window (row − (K−1))
- o_win_col  out  $clog2(IMG_W)  output column of the window (col − (K−1))
- o_win_cnt  out  CW  windows emitted this frame
- o_busy  out  1  state ≠ IDLE
- o_frame_done  out  1  one-cycle pulse at end of frame

## Operation
- Accept = i_valid && o_ready.
- o_ready = (state ∈ {FILL, RUN}) && !i_stall && !i_abort.
- col counter runs 0..IMG_W−1 and advances on accept. When it wraps to 0, row increments (0..IMG_H−1).
- Window condition for the accepted pixel at (row, col): row ≥ K−1 && col ≥ K−1.
- States:
  - IDLE: counters held at 0. i_start → FILL. i_valid is ignored and no pixel is accepted.
  - FILL: rows 0..K−2 are loading. An accept on (K−2, IMG_W−1) → RUN.
  - RUN: an accept on (IMG_H−1, IMG_W−1) → DONE.
  - DONE: o_frame_done = 1 for exactly one cycle, o_ready = 0, then → IDLE.
- i_abort in any non-IDLE state, including DONE:
  - → IDLE next cycle; counters and o_win_cnt cleared.
  - No o_frame_done pulse.
  - An o_win_valid already registered for the current cycle still completes.
- i_abort has priority over accept in the same cycle; that pixel is not counted.
- i_start while busy is ignored. i_start and i_abort together in IDLE: start wins.
- Arithmetic:
  - o_win_cnt is cleared on entering FILL, increments on each o_win_valid and saturates at its maximum.
  - o_win_row and o_win_col are computed unsigned. They are evaluated only when the window condition holds, so they never underflow.

## Timing
- Outputs on reset: o_win_valid = 0, o_win_row = 0, o_win_col = 0, o_win_cnt = 0, o_frame_done = 0, o_busy = 0; state = IDLE; counters = 0.
- Combinational outputs under reset: o_ready = 0, o_lb_wr_en = 0.
- Latency: o_win_valid, o_win_row and o_win_col are registered one cycle after the accepting edge.
- o_frame_done is asserted in the cycle after the final accept.
- In a gap cycle (no accept), o_win_valid = 0 next cycle; row and column are held.
- While stalled, o_ready = 0, so pixels are not consumed and windows are not produced. There is no data loss, and the stall is honoured in the same cycle.
- Back-to-back frames: i_start can be taken in the first IDLE cycle after DONE. Minimum frame period is IMG_W·IMG_H + 2 cycles.
- Reset asserted mid-frame:
  - All state returns to reset values immediately.
  - No frame_done.
  - The next frame requires a fresh i_start.

## Configuration
- CONV_STRIDE2_EN
  - Defined: the window condition additionally requires (row−(K−1)) and (col−(K−1)) to be even. o_win_row and o_win_col report the strided index, i.e. (row−(K−1))/2 and (col−(K−1))/2. Windows per frame = ⌈(IMG_W−K+1)/2⌉·⌈(IMG_H−K+1)/2⌉.
  - Undefined: stride 1. Windows per frame = (IMG_W−K+1)·(IMG_H−K+1).
  - Pixel acceptance and line-buffer writes are identical in both builds.

## Test plan
- Defaults, i_start then 1024 continuous pixels:
  - The first o_win_valid follows accept #133, at (row 4, col 4), with o_win_row = 0, o_win_col = 0.
  - Exactly 784 windows; final o_win_cnt = 784.
  - o_frame_done is a single pulse one cycle after accept #1024.
- Per row in RUN: columns 0–3 produce no window; o_win_valid is high for 28 consecutive accepts (col 4..31).
- i_stall high for 10 cycles mid-row 10: o_ready = 0 and o_lb_wr_en = 0 throughout. Afterwards the window sequence resumes with no skipped or duplicated (row, col); the total is still 784.
- i_abort after 500 accepts, then i_start and a full frame:
  - No o_frame_done after the abort; o_busy falls the next cycle.
  - The second frame yields 784 windows starting from (0, 0).
- i_rst pulsed asynchronously mid-frame: all outputs are at reset values before the next edge, and i_valid is ignored until i_start.
- With CONV_STRIDE2_EN defined, a full frame yields 196 windows. The last window is o_win_row = 13, o_win_col = 13.
